// File: rtl/instr_sequencer.sv
// Instruction sequencer: fetch, decode, issue and execute control FSM.
// Ports:
//   clk, reset (async, active-low)
//   start, start_pc       : begin execution at start_pc from IDLE/HALT
//   imem_rd, imem_addr    : registered-read instruction memory request
//   imem_rdata            : instruction word, valid the cycle after imem_rd
//   dec_en                : decoder register load enable
//   issue_valid/ready     : handshake to the execution unit
//   exec_done             : accepted instruction has completed
//   busy, halted, pc, instr_count : status
module instr_sequencer #(
    parameter int         IMEM_AW  = 8,
    parameter logic [3:0] OPC_NOP  = 4'h0,
    parameter logic [3:0] OPC_HALT = 4'hF
) (
    input  logic               clk,
    input  logic               reset,
    input  logic               start,
    input  logic [IMEM_AW-1:0] start_pc,
    output logic               imem_rd,
    output logic [IMEM_AW-1:0] imem_addr,
    input  logic [27:0]        imem_rdata,
    output logic               dec_en,
    output logic               issue_valid,
    input  logic               issue_ready,
    input  logic               exec_done,
    output logic               busy,
    output logic               halted,
    output logic [IMEM_AW-1:0] pc,
    output logic [15:0]        instr_count
);

    typedef enum logic [2:0] {
        S_IDLE,
        S_FETCH,
        S_DECODE,
        S_ISSUE,
        S_EXEC,
        S_HALT
    } state_t;

    state_t             state_q, state_d;
    logic [IMEM_AW-1:0] pc_q, pc_d;
    logic [15:0]        cnt_q, cnt_d;

    logic [3:0]         opcode;
    logic [IMEM_AW-1:0] pc_inc;
    logic [15:0]        cnt_inc;
    logic               unused_rdata;

    // Only the opcode field steers sequencing; the rest of the word
    // belongs to the external decoder.
    assign opcode       = imem_rdata[3:0];
    assign unused_rdata = ^imem_rdata[27:4];

    // Natural overflow gives the modulo-2^IMEM_AW wrap.
    assign pc_inc  = pc_q + {{(IMEM_AW-1){1'b0}}, 1'b1};
    assign cnt_inc = (cnt_q == 16'hFFFF) ? cnt_q : cnt_q + 16'd1;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q <= S_IDLE;
            pc_q    <= '0;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            pc_q    <= pc_d;
            cnt_q   <= cnt_d;
        end
    end

    always_comb begin
        state_d = state_q;
        pc_d    = pc_q;
        cnt_d   = cnt_q;
        case (state_q)
            S_IDLE, S_HALT: begin
                if (start) begin
                    pc_d    = start_pc;
                    cnt_d   = '0;
                    state_d = S_FETCH;
                end
            end
            S_FETCH: begin
                state_d = S_DECODE;
            end
            S_DECODE: begin
                if (opcode == OPC_HALT) begin
                    state_d = S_HALT;
                end else if (opcode == OPC_NOP) begin
                    // NOP retires here without touching the execution unit.
                    pc_d    = pc_inc;
                    cnt_d   = cnt_inc;
                    state_d = S_FETCH;
                end else begin
                    state_d = S_ISSUE;
                end
            end
            S_ISSUE: begin
                if (issue_ready) begin
                    state_d = S_EXEC;
                end
            end
            S_EXEC: begin
                if (exec_done) begin
                    pc_d    = pc_inc;
                    cnt_d   = cnt_inc;
                    state_d = S_FETCH;
                end
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    // Outputs are pure state decodes so an async reset clears them
    // without waiting for a clock edge, and they can never overlap.
    assign imem_rd     = (state_q == S_FETCH);
    assign dec_en      = (state_q == S_DECODE);
    assign issue_valid = (state_q == S_ISSUE);
    assign busy        = (state_q == S_FETCH) || (state_q == S_DECODE) ||
                         (state_q == S_ISSUE) || (state_q == S_EXEC);
    assign halted      = (state_q == S_HALT);
    assign imem_addr   = pc_q;
    assign pc          = pc_q;
    assign instr_count = cnt_q;

endmodule

// File: tb/tb_instr_sequencer.sv
// Directed self-checking bench for instr_sequencer.
// One task per scenario; expected values are hand-computed constants.
module tb_instr_sequencer;

    logic        clk;
    logic        reset;
    logic        start;
    logic [7:0]  start_pc;
    logic        imem_rd;
    logic [7:0]  imem_addr;
    logic [27:0] imem_rdata;
    logic        dec_en;
    logic        issue_valid;
    logic        issue_ready;
    logic        exec_done;
    logic        busy;
    logic        halted;
    logic [7:0]  pc;
    logic [15:0] instr_count;

    int vecs;
    int errs;

    logic [27:0] mem [256];

    int       fetch_cnt;
    int       dec_cnt;
    int       valid_cyc;
    int       issue_cnt;
    int       excl_viol;
    logic [7:0] last_fa;
    logic [7:0] prev_fa;

    instr_sequencer dut (
        .clk         (clk),
        .reset       (reset),
        .start       (start),
        .start_pc    (start_pc),
        .imem_rd     (imem_rd),
        .imem_addr   (imem_addr),
        .imem_rdata  (imem_rdata),
        .dec_en      (dec_en),
        .issue_valid (issue_valid),
        .issue_ready (issue_ready),
        .exec_done   (exec_done),
        .busy        (busy),
        .halted      (halted),
        .pc          (pc),
        .instr_count (instr_count)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Registered-read instruction memory.
    always @(posedge clk) begin
        if (imem_rd) imem_rdata <= mem[imem_addr];
    end

    // Activity monitors; tasks compare deltas against a baseline.
    initial begin
        fetch_cnt = 0;
        dec_cnt   = 0;
        valid_cyc = 0;
        issue_cnt = 0;
        excl_viol = 0;
        last_fa   = '0;
        prev_fa   = '0;
    end

    always @(posedge clk) begin
        if (imem_rd) begin
            fetch_cnt <= fetch_cnt + 1;
            prev_fa   <= last_fa;
            last_fa   <= imem_addr;
        end
        if (dec_en) dec_cnt <= dec_cnt + 1;
        if (issue_valid) valid_cyc <= valid_cyc + 1;
        if (issue_valid && issue_ready) issue_cnt <= issue_cnt + 1;
        if ((imem_rd + dec_en + issue_valid) > 1) excl_viol <= excl_viol + 1;
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic run_to_halt(input int max, output bit ok);
        int n;
        n  = 0;
        ok = 1'b0;
        while (n < max && !ok) begin
            if (halted) ok = 1'b1;
            else tick();
            n++;
        end
    endtask

    task automatic pulse_start(input logic [7:0] a);
        start    = 1'b1;
        start_pc = a;
        tick();
        start    = 1'b0;
    endtask

    task automatic test_reset();
        #1;
        vecs++;
        if ({imem_rd, dec_en, issue_valid, busy, halted} !== 5'b0) begin
            errs++;
            $display("FAIL reset_ctl: got %b want 00000",
                     {imem_rd, dec_en, issue_valid, busy, halted});
        end
        vecs++;
        if (pc !== 8'h00 || instr_count !== 16'h0) begin
            errs++;
            $display("FAIL reset_regs: pc %h cnt %h want 0/0", pc, instr_count);
        end
        reset = 1'b1;
        repeat (3) tick();
        vecs++;
        if (busy !== 1'b0 || imem_rd !== 1'b0 || halted !== 1'b0) begin
            errs++;
            $display("FAIL idle_hold: busy %b rd %b halted %b want 0",
                     busy, imem_rd, halted);
        end
    endtask

    task automatic test_basic();
        int bi;
        bi = issue_cnt;
        mem[8'h10] = 28'hABCDE01;
        mem[8'h11] = 28'h000000F;
        issue_ready = 1'b1;
        pulse_start(8'h10);
        vecs++;
        if (imem_rd !== 1'b1 || imem_addr !== 8'h10 || busy !== 1'b1) begin
            errs++;
            $display("FAIL basic_fetch: rd %b addr %h busy %b want 1/10/1",
                     imem_rd, imem_addr, busy);
        end
        tick();
        vecs++;
        if ({imem_rd, dec_en, issue_valid} !== 3'b010) begin
            errs++;
            $display("FAIL basic_decode: got %b want 010",
                     {imem_rd, dec_en, issue_valid});
        end
        tick();
        vecs++;
        if ({imem_rd, dec_en, issue_valid} !== 3'b001) begin
            errs++;
            $display("FAIL basic_issue: got %b want 001",
                     {imem_rd, dec_en, issue_valid});
        end
        tick();
        vecs++;
        if (issue_valid !== 1'b0 || busy !== 1'b1) begin
            errs++;
            $display("FAIL basic_exec: valid %b busy %b want 0/1",
                     issue_valid, busy);
        end
        exec_done = 1'b1;
        tick();
        exec_done = 1'b0;
        vecs++;
        if (pc !== 8'h11 || instr_count !== 16'd1 || imem_rd !== 1'b1) begin
            errs++;
            $display("FAIL basic_retire: pc %h cnt %0d rd %b want 11/1/1",
                     pc, instr_count, imem_rd);
        end
        tick();
        tick();
        vecs++;
        if (halted !== 1'b1 || busy !== 1'b0 || pc !== 8'h11 ||
            instr_count !== 16'd1 || (issue_cnt - bi) !== 1) begin
            errs++;
            $display("FAIL basic_halt: h %b b %b pc %h cnt %0d iss %0d want 1/0/11/1/1",
                     halted, busy, pc, instr_count, issue_cnt - bi);
        end
        issue_ready = 1'b0;
    endtask

    task automatic test_backpressure();
        int bf, bd, bv, bad;
        mem[8'h20] = 28'h5555553;
        mem[8'h21] = 28'h000000F;
        issue_ready = 1'b0;
        bf = fetch_cnt;
        bd = dec_cnt;
        bv = valid_cyc;
        bad = 0;
        pulse_start(8'h20);
        tick();
        tick();
        for (int i = 0; i < 5; i++) begin
            if (issue_valid !== 1'b1) bad++;
            tick();
        end
        vecs++;
        if (bad != 0 || issue_valid !== 1'b1) begin
            errs++;
            $display("FAIL bp_hold: dropped %0d cycles, valid %b want 0/1",
                     bad, issue_valid);
        end
        issue_ready = 1'b1;
        tick();
        issue_ready = 1'b0;
        exec_done = 1'b1;
        tick();
        exec_done = 1'b0;
        tick();
        tick();
        vecs++;
        if ((valid_cyc - bv) !== 6 || (dec_cnt - bd) !== 2 ||
            (fetch_cnt - bf) !== 2) begin
            errs++;
            $display("FAIL bp_counts: valid %0d dec %0d fetch %0d want 6/2/2",
                     valid_cyc - bv, dec_cnt - bd, fetch_cnt - bf);
        end
        vecs++;
        if (halted !== 1'b1 || pc !== 8'h21 || instr_count !== 16'd1) begin
            errs++;
            $display("FAIL bp_end: h %b pc %h cnt %0d want 1/21/1",
                     halted, pc, instr_count);
        end
    endtask

    task automatic test_nop_skip();
        int bv;
        bit ok;
        mem[8'h00] = 28'h1234560;
        mem[8'h01] = 28'h0000000;
        mem[8'h02] = 28'h000000F;
        issue_ready = 1'b1;
        bv = valid_cyc;
        pulse_start(8'h00);
        run_to_halt(30, ok);
        vecs++;
        if (!ok) begin
            errs++;
            $display("FAIL nop_timeout: halted %b want 1", halted);
        end
        vecs++;
        if ((valid_cyc - bv) !== 0 || instr_count !== 16'd2 || pc !== 8'h02) begin
            errs++;
            $display("FAIL nop_result: valid %0d cnt %0d pc %h want 0/2/02",
                     valid_cyc - bv, instr_count, pc);
        end
        issue_ready = 1'b0;
    endtask

    task automatic test_wrap();
        bit ok;
        mem[8'hFF] = 28'h0000002;
        mem[8'h00] = 28'h000000F;
        issue_ready = 1'b1;
        exec_done   = 1'b1;
        pulse_start(8'hFF);
        run_to_halt(30, ok);
        exec_done   = 1'b0;
        issue_ready = 1'b0;
        vecs++;
        if (!ok || prev_fa !== 8'hFF || last_fa !== 8'h00) begin
            errs++;
            $display("FAIL wrap_fetch: ok %b first %h second %h want 1/FF/00",
                     ok, prev_fa, last_fa);
        end
        vecs++;
        if (instr_count !== 16'd1 || pc !== 8'h00) begin
            errs++;
            $display("FAIL wrap_regs: cnt %0d pc %h want 1/00", instr_count, pc);
        end
    endtask

    task automatic test_ignored();
        bit ok;
        mem[8'h30] = 28'h0000005;
        mem[8'h31] = 28'h000000F;
        issue_ready = 1'b0;
        pulse_start(8'h30);
        tick();
        tick();
        exec_done = 1'b1;
        tick();
        exec_done = 1'b0;
        vecs++;
        if (issue_valid !== 1'b1 || pc !== 8'h30 || instr_count !== 16'd0) begin
            errs++;
            $display("FAIL ign_done: valid %b pc %h cnt %0d want 1/30/0",
                     issue_valid, pc, instr_count);
        end
        issue_ready = 1'b1;
        tick();
        issue_ready = 1'b0;
        pulse_start(8'h55);
        vecs++;
        if (busy !== 1'b1 || imem_rd !== 1'b0 || issue_valid !== 1'b0 ||
            pc !== 8'h30 || instr_count !== 16'd0) begin
            errs++;
            $display("FAIL ign_start: busy %b rd %b v %b pc %h cnt %0d want 1/0/0/30/0",
                     busy, imem_rd, issue_valid, pc, instr_count);
        end
        exec_done = 1'b1;
        tick();
        exec_done = 1'b0;
        vecs++;
        if (imem_addr !== 8'h31 || instr_count !== 16'd1) begin
            errs++;
            $display("FAIL ign_resume: addr %h cnt %0d want 31/1",
                     imem_addr, instr_count);
        end
        run_to_halt(10, ok);
        vecs++;
        if (!ok || pc !== 8'h31) begin
            errs++;
            $display("FAIL ign_halt: ok %b pc %h want 1/31", ok, pc);
        end
    endtask

    task automatic test_async_reset();
        bit ok;
        mem[8'h40] = 28'h0000006;
        mem[8'h41] = 28'h000000F;
        issue_ready = 1'b0;
        pulse_start(8'h40);
        tick();
        tick();
        #2 reset = 1'b0;
        #1;
        vecs++;
        if ({imem_rd, dec_en, issue_valid, busy, halted} !== 5'b0 ||
            pc !== 8'h00 || instr_count !== 16'h0) begin
            errs++;
            $display("FAIL arst_issue: ctl %b pc %h cnt %0d want 0",
                     {imem_rd, dec_en, issue_valid, busy, halted}, pc, instr_count);
        end
        #1 reset = 1'b1;
        tick();
        vecs++;
        if (busy !== 1'b0 || halted !== 1'b0) begin
            errs++;
            $display("FAIL arst_idle: busy %b halted %b want 0/0", busy, halted);
        end
        issue_ready = 1'b1;
        pulse_start(8'h40);
        tick();
        tick();
        tick();
        issue_ready = 1'b0;
        #2 reset = 1'b0;
        #1;
        vecs++;
        if ({imem_rd, dec_en, issue_valid, busy, halted} !== 5'b0 ||
            pc !== 8'h00 || instr_count !== 16'h0) begin
            errs++;
            $display("FAIL arst_exec: ctl %b pc %h cnt %0d want 0",
                     {imem_rd, dec_en, issue_valid, busy, halted}, pc, instr_count);
        end
        #1 reset = 1'b1;
        tick();
        issue_ready = 1'b1;
        exec_done   = 1'b1;
        pulse_start(8'h40);
        run_to_halt(20, ok);
        issue_ready = 1'b0;
        exec_done   = 1'b0;
        vecs++;
        if (!ok || pc !== 8'h41 || instr_count !== 16'd1) begin
            errs++;
            $display("FAIL arst_restart: ok %b pc %h cnt %0d want 1/41/1",
                     ok, pc, instr_count);
        end
    endtask

    task automatic test_exclusive();
        vecs++;
        if (excl_viol !== 0) begin
            errs++;
            $display("FAIL exclusive: overlap cycles %0d want 0", excl_viol);
        end
    endtask

    initial begin
        vecs        = 0;
        errs        = 0;
        reset       = 1'b0;
        start       = 1'b0;
        start_pc    = '0;
        issue_ready = 1'b0;
        exec_done   = 1'b0;
        imem_rdata  = '0;
        for (int i = 0; i < 256; i++) mem[i] = 28'h0;
        test_reset();
        test_basic();
        test_backpressure();
        test_nop_skip();
        test_wrap();
        test_ignored();
        test_async_reset();
        test_exclusive();
        $display("== %0d vectors applied, %0d miscompares ==", vecs, errs);
        $finish;
    end

endmodule
